// File: rtl/parity_serial_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, parity bit, stop(1).
// Recomputes XOR parity and reports data_valid, parity_err and frame_err as one-cycle pulses.
module parity_serial_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic             ODD_BIT   = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Nonzero result means the received parity bit disagrees with the data.
    function automatic logic parity_check(input logic running, input logic par_bit);
        return running ^ par_bit ^ ODD_BIT;
    endfunction

    state_t              state_r, state_n;
    logic                sync_1_r;
    logic                rx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_n;
    logic [IDX_W-1:0]    idx_r, idx_n;
    logic [DATA_W-1:0]   shift_r, shift_n;
    logic [DATA_W:0]     shift_ext_s;
    logic                par_r, par_n;
    logic                err_r, err_n;
    logic [DATA_W-1:0]   data_r, data_n;
    logic                valid_r, valid_n;
    logic                perr_r, perr_n;
    logic                ferr_r, ferr_n;
    logic                busy_r, busy_n;

    assign data_out   = data_r;
    assign data_valid = valid_r;
    assign parity_err = perr_r;
    assign frame_err  = ferr_r;
    assign busy       = busy_r;

    // Two-flop synchroniser; the line idles high so both flops reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1_r <= 1'b1;
            rx_s     <= 1'b1;
        end else begin
            sync_1_r <= rx_in;
            rx_s     <= sync_1_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            par_r   <= 1'b0;
            err_r   <= 1'b0;
            data_r  <= '0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            idx_r   <= idx_n;
            shift_r <= shift_n;
            par_r   <= par_n;
            err_r   <= err_n;
            data_r  <= data_n;
            valid_r <= valid_n;
            perr_r  <= perr_n;
            ferr_r  <= ferr_n;
            busy_r  <= busy_n;
        end
    end

    // Next-state and output decode; sampled bits enter at the MSB and shift down,
    // so after DATA_W samples the first bit received sits at the LSB.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        idx_n       = idx_r;
        shift_n     = shift_r;
        par_n       = par_r;
        err_n       = err_r;
        data_n      = data_r;
        valid_n     = 1'b0;
        perr_n      = 1'b0;
        ferr_n      = 1'b0;
        shift_ext_s = {rx_s, shift_r};
        case (state_r)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_DATA;
                        idx_n   = '0;
                        par_n   = 1'b0;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = shift_ext_s[DATA_W:1];
                    par_n   = par_r ^ rx_s;
                    if (idx_r == IDX_LAST) begin
                        state_n = S_PARITY;
                    end else begin
                        idx_n = idx_r + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = '0;
                    err_n   = parity_check(par_r, rx_s);
                    state_n = S_STOP;
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    if (rx_s) begin
                        data_n  = shift_r;
                        valid_n = 1'b1;
                        perr_n  = err_r;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
        // busy covers the pulse cycle too, dropping on the cycle after it.
        busy_n = (state_n != S_IDLE) || valid_n || ferr_n;
    end

endmodule

// File: tb/tb_parity_serial_rx.sv
// Scoreboard bench for parity_serial_rx: one even-parity and one odd-parity instance,
// directed frames push expected results, a monitor pops them on each output pulse.
module tb_parity_serial_rx;

    localparam int CPB = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_e, rx_o;
    logic [7:0] data_out_e, data_out_o;
    logic       data_valid_e, data_valid_o;
    logic       parity_err_e, parity_err_o;
    logic       frame_err_e, frame_err_o;
    logic       busy_e, busy_o;

    exp_t q_e[$];
    exp_t q_o[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parity_serial_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_e), .data_out(data_out_e),
        .data_valid(data_valid_e), .parity_err(parity_err_e),
        .frame_err(frame_err_e), .busy(busy_e)
    );

    parity_serial_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_o), .data_out(data_out_o),
        .data_valid(data_valid_o), .parity_err(parity_err_o),
        .frame_err(frame_err_o), .busy(busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_line(input bit odd, input logic b);
        if (odd) rx_o = b;
        else     rx_e = b;
    endtask

    task automatic send_frame(input bit odd, input logic [7:0] d, input logic par,
                              input logic stop, input int idle_bits);
        logic b;
        for (int i = 0; i < 11; i++) begin
            if (i == 0)      b = 1'b0;
            else if (i <= 8) b = d[i-1];
            else if (i == 9) b = par;
            else             b = stop;
            drive_line(odd, b);
            repeat (CPB) @(negedge clk);
        end
        drive_line(odd, 1'b1);
        repeat (idle_bits * CPB) @(negedge clk);
    endtask

    task automatic compare_pulse(input string tag, input exp_t e, input logic v,
                                 input logic pe, input logic fe, input logic [7:0] d);
        chk({tag, "_data_out"}, {24'd0, d}, {24'd0, e.d});
        chk({tag, "_data_valid"}, {31'd0, v}, {31'd0, ~e.fe});
        chk({tag, "_parity_err"}, {31'd0, pe}, {31'd0, e.pe});
        chk({tag, "_frame_err"}, {31'd0, fe}, {31'd0, e.fe});
    endtask

    // Monitor: every pulse on either instance is matched against its queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_valid_e || frame_err_e) begin
                chk("even_exclusive", {31'd0, data_valid_e & frame_err_e}, 32'd0);
                if (q_e.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL even_unexpected_pulse: got valid=%0b frame_err=%0b expected no pulse",
                             data_valid_e, frame_err_e);
                end else begin
                    e = q_e.pop_front();
                    compare_pulse("even", e, data_valid_e, parity_err_e, frame_err_e, data_out_e);
                end
            end
            if (data_valid_o || frame_err_o) begin
                chk("odd_exclusive", {31'd0, data_valid_o & frame_err_o}, 32'd0);
                if (q_o.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL odd_unexpected_pulse: got valid=%0b frame_err=%0b expected no pulse",
                             data_valid_o, frame_err_o);
                end else begin
                    e = q_o.pop_front();
                    compare_pulse("odd", e, data_valid_o, parity_err_o, frame_err_o, data_out_o);
                end
            end
        end
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && (q_e.size() != 0 || q_o.size() != 0); i++) @(negedge clk);
        chk({tag, "_even_pending"}, q_e.size(), 32'd0);
        chk({tag, "_odd_pending"}, q_o.size(), 32'd0);
    endtask

    initial begin
        logic saw_busy;
        rst_n = 1'b0;
        rx_e  = 1'b1;
        rx_o  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data_out", {24'd0, data_out_e}, 32'd0);
        chk("reset_flags", {28'd0, data_valid_e, parity_err_e, frame_err_e, busy_e}, 32'd0);
        chk("reset_odd_flags", {28'd0, data_valid_o, parity_err_o, frame_err_o, busy_o}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Good frame, good parity, then a parity error, then a framing error.
        q_e.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 2);
        chk("t1_busy_low", {31'd0, busy_e}, 32'd0);
        q_e.push_back('{d: 8'h01, pe: 1'b1, fe: 1'b0});
        send_frame(1'b0, 8'h01, 1'b0, 1'b1, 2);
        q_e.push_back('{d: 8'h01, pe: 1'b0, fe: 1'b1});
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 2);
        drain("t3");

        // One-cycle glitch is rejected at the mid-start re-check.
        rx_e = 1'b0;
        @(negedge clk);
        rx_e = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy_e) saw_busy = 1'b1;
        end
        chk("t4_busy_seen", {31'd0, saw_busy}, 32'd1);
        chk("t4_busy_low", {31'd0, busy_e}, 32'd0);
        chk("t4_data_out", {24'd0, data_out_e}, 32'h01);

        // Reset in the middle of data bit 3 of a 0xFF frame.
        rx_e = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_e = 1'b1;
        repeat (3 * CPB + 2) @(negedge clk);
        chk("t5_busy_before_reset", {31'd0, busy_e}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_data_out", {24'd0, data_out_e}, 32'd0);
        chk("t5_reset_flags", {28'd0, data_valid_e, parity_err_e, frame_err_e, busy_e}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_idle_after_reset", {31'd0, busy_e}, 32'd0);
        q_e.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 2);

        // Odd parity, back-to-back frames separated by one idle bit.
        q_o.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b0});
        q_o.push_back('{d: 8'h00, pe: 1'b1, fe: 1'b0});
        q_o.push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b0});
        send_frame(1'b1, 8'h00, 1'b1, 1'b1, 1);
        send_frame(1'b1, 8'h00, 1'b0, 1'b1, 1);
        send_frame(1'b1, 8'hC3, 1'b1, 1'b1, 2);
        drain("final");
        chk("final_odd_data_out", {24'd0, data_out_o}, 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
Serial frame receiver that checks XOR parity. It deserialises frames in the form start(0), DATA_W data bits LSB-first, parity bit, stop(1), and recomputes parity as the XOR reduction of the received data bits. It presents the data word with valid, parity-error and framing-error indications. It is the receiving end of the team's serial parity link: the transmitter drives the XOR parity bit, and this block decodes and checks it.

Parameters:
DATA_W, 8, number of data bits per frame (1..16)
CLKS_PER_BIT, 4, clock cycles per serial bit; must be even and >= 4
ODD_PARITY, 0, 0 = even parity (XOR of data ^ parity == 0); 1 = odd parity (== 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rx_in  input  1  serial line; idle high; asynchronous to clk
data_out  output  DATA_W  last frame's data word, LSB = first data bit received
data_valid  output  1  one-cycle pulse: frame with good stop bit received
parity_err  output  1  one-cycle pulse coincident with data_valid when parity check fails
frame_err  output  1  one-cycle pulse when the stop bit samples 0
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst_n low, async): state = IDLE, all counters 0, data_out = 0, data_valid = parity_err = frame_err = busy = 0, synchroniser flops = 1.
- Input path: 2-flop synchroniser on rx_in; rx_s is the second flop. All sampling uses rx_s, so line-to-FSM latency is 2 cycles.
- IDLE: when rx_s == 0, go to START, clear the cycle counter, and set busy on the next edge.
- START: count CLKS_PER_BIT/2 - 1 cycles to reach mid-bit, then sample rx_s.
  - rx_s == 1: false start; return to IDLE with no output pulses.
  - rx_s == 0: go to DATA with bit index 0 and running parity 0.
- DATA: sample every CLKS_PER_BIT cycles. Shift the sampled bit into shift register position [index] (LSB first) and XOR it into running parity. Go to PARITY after index DATA_W-1.
- PARITY: sample after CLKS_PER_BIT cycles. err = running_parity ^ sampled_bit ^ ODD_PARITY. Latch err.
- STOP: sample after CLKS_PER_BIT cycles.
  - rx_s == 1: on the next edge, data_out <= shift register, data_valid = 1, parity_err = latched err (both for one cycle).
  - rx_s == 0: frame_err = 1 for one cycle; data_valid and parity_err stay 0; data_out is unchanged.
  - Either way, return to IDLE in the same edge that raises the pulse. A new frame is accepted once rx_s is high again. A low rx_s in IDLE on the cycle after a framing error starts a new frame; no break handling.
- data_out holds its value between frames. It changes only on a valid stop.
- Output latency: data_valid rises 2 + CLKS_PER_BIT/2 + (DATA_W+2)*CLKS_PER_BIT cycles (+/-1 for edge alignment) after the falling edge of rx_in.
- Glitches: a low pulse shorter than CLKS_PER_BIT/2 cycles is rejected by the START re-check.
- Reset mid-frame: all state clears immediately. After release, the block waits in IDLE; a line still low is treated as a new start.
- data_valid and frame_err are never high in the same cycle.
- busy stays 1 from the cycle after start detection through the cycle the pulse is issued. It is 0 in the following cycle.

Test Plan:
1. CLKS_PER_BIT=4, DATA_W=8, even parity. Send 0xA5 (bits 1,0,1,0,0,1,0,1), parity 0, stop 1 -> data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, busy low afterwards.
2. Send 0x01 with parity bit 0 (correct is 1), stop 1 -> data_valid=1 and parity_err=1 in the same cycle, data_out=0x01.
3. Send 0x3C, parity 0, stop bit 0 -> frame_err pulse, data_valid=0, data_out keeps the previous 0x01.
4. Drive rx_in low for 1 cycle while idle -> busy rises briefly and returns to 0; no data_valid or frame_err pulse; data_out unchanged.
5. Assert rst_n low during data bit 3 of a 0xFF frame, then release with the line high -> all outputs 0, data_out=0. A following 0x5A frame with parity 0 is received correctly.
6. ODD_PARITY=1: send 0x00 with parity 1 -> parity_err=0. Send 0x00 with parity 0 -> parity_err=1. Back-to-back frames with a single idle bit between them are both received.
